immgen_pipe: RTL
================

# immgen_pipe

Parametrised, buffered immediate generator for the RISC-V decode path. It accepts raw 32-bit instructions over a valid/ready handshake and works out the immediate format, either from the opcode or from an explicit select input. It produces the sign- or zero-extended XLEN-wide immediate together with a format code and an illegal flag, and queues results in a DEPTH-entry FIFO. It sits between fetch and the execute-stage operand muxes, adding RV64 widths, CSR zimm and shift-amount formats, opcode auto-decode, backpressure and flush.

## Interface
Parameters:
- XLEN, 32: immediate width; only 32 or 64 are legal.
- DEPTH, 2: output FIFO entries; legal range 2..8, power of two.
- AUTO_DECODE, 1: 1 = derive format from opcode; 0 = use in_immsel.
- TAG_W, 5: width of the sideband tag carried with each entry.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties the FIFO.
- in_valid  in  1  instruction offered.
- in_ready  out  1  entry will be accepted.
- in_inst  in  32  raw instruction.
- in_immsel  in  3  explicit format; used only when AUTO_DECODE=0.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  format code.
- out_illegal  out  1  unrecognised encoding.
- out_tag  out  TAG_W  tag of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
Format codes:
- 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shift amount).

Immediate by format:
- R: imm = 0.
- I, S, B, U, J: standard RISC-V bit placement, sign-extended from inst[31] to XLEN. U is sign-extended from bit 31 when XLEN=64.
- Z: zero-extended inst[19:15].
- SH: zero-extended inst[24:20] when XLEN=32; inst[25:20] when XLEN=64.

Auto-decode by opcode:
- 0110011 → R.
- 0000011, 1100111, 0001111 → I.
- 0010011 → SH when funct3 is 001 or 101; otherwise I.
- 1110011 → Z when funct3[2]=1; otherwise I.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.
- Any other opcode, or inst[1:0]≠11 → fmt 0, imm 0, illegal=1.

Explicit mode (AUTO_DECODE=0):
- in_immsel is used directly.
- illegal=1 only when inst[1:0]≠11.

Handshake and FIFO:
- Push when in_valid && in_ready.
- Pop when out_valid && out_ready.
- The immediate is computed combinationally at push and stored with fmt, illegal and tag.
- in_ready = (count < DEPTH) && !flush. It is a registered-state function, with no combinational path from out_ready.
- out_valid = (count ≠ 0).
- Outputs show the head entry and stay stable while out_valid && !out_ready.
- Push and pop in the same cycle: count is unchanged, pointers both advance.
- Full: in_ready=0; a pop that cycle does not enable a push.
- Empty: out_valid=0 and out_* are don't-care. Once reset, the bench must check out_imm=0 only.
- Pointers wrap modulo DEPTH.
- Flush: next cycle count=0 and pointers=0. Any concurrent input is not accepted and any concurrent pop is discarded.

## Timing
- Latency: an entry pushed at edge N is visible at out_* after edge N, i.e. in cycle N+1.
- Throughput: one entry per cycle sustained when out_ready=1 and DEPTH≥2.
- Reset values (asynchronous, on rst_n low):
  - count=0, out_valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Pointers=0.
- Reset mid-operation: all entries are lost immediately; no partial pop is observable.
- rst_n deassertion is synchronised externally.

## Structure
- Package imm_pkg holds:
  - the imm_fmt_e enum (3-bit codes above);
  - opcode localparams;
  - the function decode_fmt(inst) returning fmt and illegal.
- Sub-module imm_extract:
  - purely combinational;
  - inputs fmt, inst; parameter XLEN; output imm.
- FIFO storage, pointers and count live inline in immgen_pipe as one packed entry array.

## Test plan
All cases use XLEN=32, DEPTH=2, AUTO_DECODE=1 unless stated.
- Single pushes, out_ready=1 → out_fmt/out_imm as follows:
  - 0xFFF00093 → fmt 1, imm 0xFFFFFFFF.
  - 0x00112623 → fmt 2, imm 0x0000000C.
  - 0xFE000EE3 → fmt 3, imm 0xFFFFFFFC.
  - 0x123452B7 → fmt 4, imm 0x12345000.
  - 0x001000EF → fmt 5, imm 0x00000800.
- Special formats:
  - 0x300FD073 → fmt 6, imm 31.
  - 0x0000007F → illegal=1, imm 0.
  - XLEN=64, 0x03F01013 → fmt 7, imm 63.
  - XLEN=64, 0x800002B7 → imm 0xFFFFFFFF80000000.
- Backpressure: out_ready=0, push 3 instructions with tags 1,2,3:
  - after 2 pushes, in_ready=0 and count=2;
  - tag 3 is held off;
  - raise out_ready → tags emerge in order 1,2,3 with no loss or duplication.
- Simultaneous push/pop with count=1 for 8 cycles → count stays 1 and output order matches input order.
- Flush with count=2 while in_valid=1 → next cycle count=0 and out_valid=0; the offered instruction is not enqueued.
- Drop rst_n asynchronously mid-stream with count=2 → outputs reach their reset values before the next clk edge; after release the first push is the first output.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format codes, RISC-V opcodes and the opcode-to-format decoder.
// Contents:
//   imm_fmt_e  - 3-bit immediate format code (R, I, S, B, U, J, Z, SH)
//   dec_t      - decoder result: format plus illegal flag
//   OP_*       - major opcode values recognised by the decoder
//   decode_fmt - maps a raw instruction to its format and illegal flag
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_Z  = 3'd6,
        FMT_SH = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } dec_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Every recognised opcode ends in 2'b11, so compressed encodings fall to the default arm.
    function automatic dec_t decode_fmt(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        f3 = inst[14:12];
        d  = '{fmt: FMT_R, illegal: 1'b0};
        case (inst[6:0])
            OP_REG:                     d.fmt = FMT_R;
            OP_LOAD, OP_JALR, OP_FENCE: d.fmt = FMT_I;
            OP_IMM:                     d.fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            OP_SYSTEM:                  d.fmt = f3[2] ? FMT_Z : FMT_I;
            OP_STORE:                   d.fmt = FMT_S;
            OP_BRANCH:                  d.fmt = FMT_B;
            OP_LUI, OP_AUIPC:           d.fmt = FMT_U;
            OP_JAL:                     d.fmt = FMT_J;
            default:                    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and extension for one instruction.
// Ports:
//   fmt  in  3     immediate format code
//   inst in  31:7  instruction bits above the opcode field
//   imm  out XLEN  sign- or zero-extended immediate
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  imm_fmt_e         fmt,
    input  logic [31:7]      inst,
    output logic [XLEN-1:0]  imm
);

    // Size casts of signed operands sign-extend to XLEN, which also covers RV64 U-type.
    always_comb begin
        case (fmt)
            FMT_I:   imm = XLEN'($signed(inst[31:20]));
            FMT_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            FMT_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            FMT_Z:   imm = XLEN'(inst[19:15]);
            FMT_SH:  imm = XLEN'({(XLEN == 64) && inst[25], inst[24:20]});
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: buffered RISC-V immediate generator with valid/ready input and a DEPTH-entry output FIFO.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous FIFO clear; blocks concurrent push and pop
//   in_valid/in_ready       input handshake
//   in_inst, in_immsel      raw instruction, explicit format (AUTO_DECODE=0 only)
//   in_tag                  sideband tag carried with the entry
//   out_valid/out_ready     output handshake on the FIFO head
//   out_imm, out_fmt        head immediate and format code
//   out_illegal, out_tag    head illegal flag and tag
//   count                   FIFO occupancy
module immgen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int AUTO_DECODE = 1,
    parameter int TAG_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [2:0]                 in_immsel,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_fmt,
    output logic                       out_illegal,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             illegal;
        imm_fmt_e         fmt;
        logic [XLEN-1:0]  imm;
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    entry_t             wr_entry;
    entry_t             head;
    dec_t               dec;
    imm_fmt_e           fmt;
    logic [XLEN-1:0]    imm;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    assign dec = decode_fmt(in_inst);
    assign fmt = (AUTO_DECODE != 0) ? dec.fmt : imm_fmt_e'(in_immsel);

    imm_extract #(.XLEN(XLEN)) u_extract (
        .fmt  (fmt),
        .inst (in_inst[31:7]),
        .imm  (imm)
    );

    assign wr_entry = '{
        tag:     in_tag,
        illegal: (AUTO_DECODE != 0) ? dec.illegal : (in_inst[1:0] != 2'b11),
        fmt:     fmt,
        imm:     imm
    };

    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem[rd_ptr];

    // Empty FIFO presents zeros so stale storage never leaks out after reset, pop or flush.
    assign out_imm     = out_valid ? head.imm : '0;
    assign out_fmt     = out_valid ? head.fmt : FMT_R;
    assign out_illegal = out_valid && head.illegal;
    assign out_tag     = out_valid ? head.tag : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
